ps2_key_decoder: RTL

//  Receives PS/2 keyboard frames (scan code set 2) and turns them into held key levels
//  (key_space, key_left, key_right) for the game controller. Sits between the board
//  PS/2 pins and the jump/move control FSM. Includes a bit-level receiver and a

---
 rtl/keyboard_pkg.sv | 24 ++
 rtl/ps2_rx.sv | 134 +++++++++++++
 rtl/ps2_key_decoder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/keyboard_pkg.sv
// Scan-code set 2 constants and receiver state type shared by the PS/2 key decoder.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVR1  = 8'hFF;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;

  typedef enum logic [1:0] {
    RxIdle,
    RxData,
    RxParity,
    RxStop
  } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 bit receiver: pin synchronisers, clock glitch filter, frame FSM and mid-frame watchdog.
module ps2_rx
  import keyboard_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned FltW = $clog2(FILTER_LEN) + 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYC) + 1;

  logic            clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic            filt_q, filt_d;
  logic [FltW-1:0] flt_cnt_q, flt_cnt_d;
  rx_state_t       state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            par_q, par_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d, err_q, err_d;
  logic            fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      flt_cnt_q  <= '0;
      state_q    <= RxIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      flt_cnt_q  <= flt_cnt_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    fall      = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (flt_cnt_q == FltW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
        fall   = filt_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    wd_d      = '0;

    if (fall) begin
      unique case (state_q)
        RxIdle: begin
          if (!dat_sync_q) begin
            state_d   = RxData;
            bit_cnt_d = '0;
          end
        end
        RxData: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RxParity;
        end
        RxParity: begin
          par_d   = dat_sync_q;
          state_d = RxStop;
        end
        RxStop: begin
          if (dat_sync_q && (^{shift_q, par_q})) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = RxIdle;
        end
        default: state_d = RxIdle;
      endcase
    end else if (state_q != RxIdle) begin
      if (wd_q == WdW'(TIMEOUT_CYC - 1)) begin
        err_d     = 1'b1;
        state_d   = RxIdle;
        bit_cnt_d = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 make/break decoder producing held key levels for space, left and right.
// Define KEY_WASD_EN to also map W/A/D onto space/left/right.
module ps2_key_decoder
  import keyboard_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  logic ext_q, ext_d, brk_q, brk_d;
  logic space_q, space_d, left_q, left_d, right_q, right_d;
`ifdef KEY_WASD_EN
  logic w_q, w_d, a_q, a_d, d_q, d_d;
`endif

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      space_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
`ifdef KEY_WASD_EN
      w_q     <= 1'b0;
      a_q     <= 1'b0;
      d_q     <= 1'b0;
`endif
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      space_q <= space_d;
      left_q  <= left_d;
      right_q <= right_d;
`ifdef KEY_WASD_EN
      w_q     <= w_d;
      a_q     <= a_d;
      d_q     <= d_d;
`endif
    end
  end

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    space_d = space_q;
    left_d  = left_q;
    right_d = right_q;
`ifdef KEY_WASD_EN
    w_d     = w_q;
    a_d     = a_q;
    d_d     = d_q;
`endif
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      case (rx_byte)
        SC_EXT:          ext_d = 1'b1;
        SC_BRK:          brk_d = 1'b1;
        SC_PAUSE, SC_BAT: ;
        SC_OVR0, SC_OVR1: begin
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          space_d = 1'b0;
          left_d  = 1'b0;
          right_d = 1'b0;
`ifdef KEY_WASD_EN
          w_d     = 1'b0;
          a_d     = 1'b0;
          d_d     = 1'b0;
`endif
        end
        default: begin
          if (rx_byte == SC_SPACE && !ext_q) space_d = !brk_q;
          if (rx_byte == SC_LEFT && ext_q)   left_d  = !brk_q;
          if (rx_byte == SC_RIGHT && ext_q)  right_d = !brk_q;
`ifdef KEY_WASD_EN
          if (rx_byte == SC_W && !ext_q) w_d = !brk_q;
          if (rx_byte == SC_A && !ext_q) a_d = !brk_q;
          if (rx_byte == SC_D && !ext_q) d_d = !brk_q;
`endif
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

`ifdef KEY_WASD_EN
  assign key_space = space_q | w_q;
  assign key_left  = left_q | a_q;
  assign key_right = right_q | d_q;
`else
  assign key_space = space_q;
  assign key_left  = left_q;
  assign key_right = right_q;
`endif

endmodule
